// File: rtl/lpf_iq_scheduler.sv
// Shared serial moving-average low-pass filter for the I and Q channels, fed by an internal sample-rate divider.
// Optional feature: define LPF_SAT_EN to saturate outputs instead of wrapping them.
module lpf_iq_scheduler #(
  parameter int DATA_WIDTH   = 7,
  parameter int TAPS         = 4,
  parameter int ACC_WIDTH    = 11,
  parameter int SHIFT        = 3,
  parameter int SYS_CLK_FREQ = 6_400_000,
  parameter int SAMPLE_RATE  = 800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int SAMPLE_DIV = SYS_CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TAP_W      = $clog2(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_Q, DONE} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [CNT_W-1:0]               count;
  logic                           tick;
  logic signed [DATA_WIDTH-1:0]   i_taps [TAPS];
  logic signed [DATA_WIDTH-1:0]   q_taps [TAPS];
  logic [TAP_W-1:0]               tap_idx;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_shifted;
  logic signed [DATA_WIDTH-1:0]   hold_i;
  logic signed [DATA_WIDTH-1:0]   result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   count <= '0;
    else if (!start)            count <= '0;
    else if (count == CNT_LAST) count <= '0;
    else                        count <= count + 1'b1;
  end

  assign tick = start && (count == CNT_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = ACC_I;
      ACC_I:   if (tap_idx == TAP_LAST) state_next = ACC_Q;
      ACC_Q:   if (tap_idx == TAP_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Floor division by 2^SHIFT, then narrowed to the output width.
  assign acc_shifted = acc >>> SHIFT;

`ifdef LPF_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    result = acc_shifted[DATA_WIDTH-1:0];
    if (acc_shifted > ACC_WIDTH'(OUT_MAX))      result = OUT_MAX;
    else if (acc_shifted < ACC_WIDTH'(OUT_MIN)) result = OUT_MIN;
  end
`else
  always_comb begin
    result = acc_shifted[DATA_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        i_taps[k] <= '0;
        q_taps[k] <= '0;
      end
      tap_idx   <= '0;
      acc       <= '0;
      hold_i    <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A tick that lands while the engine is busy is discarded and flagged.
      if (!start)                      overrun <= 1'b0;
      else if (tick && state != IDLE)  overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              i_taps[k] <= i_taps[k-1];
              q_taps[k] <= q_taps[k-1];
            end
            i_taps[0] <= i_in;
            q_taps[0] <= q_in;
            acc       <= '0;
            tap_idx   <= '0;
          end
        end
        ACC_I: begin
          acc     <= acc + ACC_WIDTH'(i_taps[tap_idx]);
          tap_idx <= (tap_idx == TAP_LAST) ? '0 : tap_idx + 1'b1;
        end
        ACC_Q: begin
          if (tap_idx == '0) begin
            hold_i <= result;
            acc    <= ACC_WIDTH'(q_taps[0]);
          end else begin
            acc    <= acc + ACC_WIDTH'(q_taps[tap_idx]);
          end
          tap_idx <= (tap_idx == TAP_LAST) ? '0 : tap_idx + 1'b1;
        end
        DONE: begin
          i_out     <= hold_i;
          q_out     <= result;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpf_iq_scheduler.sv
// Self-checking bench for lpf_iq_scheduler: scoreboard on the main instance plus
// short-divider and zero-shift instances; expectations follow LPF_SAT_EN.
module tb_lpf_iq_scheduler;

  localparam int DW = 7;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic clk;
  logic rst;

  logic                 start_a, start_b, start_c;
  logic signed [DW-1:0] i_a, q_a, i_b, q_b, i_c, q_c;
  logic signed [DW-1:0] i_out_a, q_out_a, i_out_b, q_out_b, i_out_c, q_out_c;
  logic                 valid_a, busy_a, ovr_a;
  logic                 valid_b, busy_b, ovr_b;
  logic                 valid_c, busy_c, ovr_c;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   mi[4];
  int   mq[4];
  int   b_cnt = 0, b_last_i = 0, b_last_q = 0;
  int   c_cnt = 0, c_last_i = 0, c_last_q = 0;

  lpf_iq_scheduler #(.SYS_CLK_FREQ(160), .SAMPLE_RATE(10)) dut (
    .clk(clk), .rst(rst), .start(start_a), .i_in(i_a), .q_in(q_a),
    .i_out(i_out_a), .q_out(q_out_a), .out_valid(valid_a), .busy(busy_a), .overrun(ovr_a));

  lpf_iq_scheduler #(.SYS_CLK_FREQ(80), .SAMPLE_RATE(10)) dut_div8 (
    .clk(clk), .rst(rst), .start(start_b), .i_in(i_b), .q_in(q_b),
    .i_out(i_out_b), .q_out(q_out_b), .out_valid(valid_b), .busy(busy_b), .overrun(ovr_b));

  lpf_iq_scheduler #(.SYS_CLK_FREQ(160), .SAMPLE_RATE(10), .SHIFT(0)) dut_shift0 (
    .clk(clk), .rst(rst), .start(start_c), .i_in(i_c), .q_in(q_c),
    .i_out(i_out_c), .q_out(q_out_c), .out_valid(valid_c), .busy(busy_c), .overrun(ovr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual %0d, expected %0d", tag, actual, expected);
  endtask

  // Reference average over four taps with floor shift, then saturate or wrap.
  function automatic int expect_out(input int s0, input int s1, input int s2, input int s3,
                                    input int shift);
    int          r;
    logic [DW-1:0] w;
    r = (s0 + s1 + s2 + s3) >>> shift;
`ifdef LPF_SAT_EN
    if (r > 63)  r = 63;
    if (r < -64) r = -64;
`else
    w = r[DW-1:0];
    r = $signed(w);
`endif
    return r;
  endfunction

  // Drive one tick's samples on the main instance, push the expected result,
  // then watch latency, busy span and output hold over the following 15 cycles.
  task automatic applyStimulus(input int iv, input int qv, input int pre_edges, input bit drop_start);
    exp_t e;
    int   stray, busy_cnt, valid_at;
    i_a = DW'(iv);
    q_a = DW'(qv);
    stray = 0;
    repeat (pre_edges - 1) begin
      @(posedge clk); #1;
      if (valid_a) stray++;
    end
    @(posedge clk);
    for (int k = 3; k > 0; k--) begin
      mi[k] = mi[k-1];
      mq[k] = mq[k-1];
    end
    mi[0] = iv;
    mq[0] = qv;
    e.i = expect_out(mi[0], mi[1], mi[2], mi[3], 3);
    e.q = expect_out(mq[0], mq[1], mq[2], mq[3], 3);
    sb.push_back(e);
    #1;
    busy_cnt = busy_a ? 1 : 0;
    valid_at = -1;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      if (drop_start && k == 3) start_a = 1'b0;
      if (valid_a && valid_at < 0) valid_at = k;
      if (busy_a) busy_cnt++;
    end
    if (pre_edges > 1) checkOutput("no_valid_before_tick", stray, 0);
    checkOutput("valid_latency", valid_at, 9);
    checkOutput("busy_cycles", busy_cnt, 9);
    checkOutput("hold_i_out", i_out_a, e.i);
    checkOutput("hold_q_out", q_out_a, e.q);
  endtask

  // Scoreboard consumer for the main instance.
  always @(negedge clk) begin
    if (rst && valid_a) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_i_out", i_out_a, mon_e.i);
        checkOutput("sb_q_out", q_out_a, mon_e.q);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && valid_b) begin
      b_cnt++;
      b_last_i = i_out_b;
      b_last_q = q_out_b;
    end
    if (rst && valid_c) begin
      c_cnt++;
      c_last_i = i_out_c;
      c_last_q = q_out_c;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int activity;
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    i_a = '0; q_a = '0; i_b = '0; q_b = '0; i_c = '0; q_c = '0;
    for (int k = 0; k < 4; k++) begin mi[k] = 0; mq[k] = 0; end

    repeat (3) @(posedge clk); #1;
    checkOutput("reset_i_out", i_out_a, 0);
    checkOutput("reset_q_out", q_out_a, 0);
    checkOutput("reset_valid", valid_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_overrun", ovr_a, 0);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) start_a = 1'b1;

    $display("[TB] steady 40/-40 input for four ticks");
    applyStimulus(40, -40, 16, 1'b0);
    for (int t = 0; t < 3; t++) applyStimulus(40, -40, 1, 1'b0);
    checkOutput("steady_i_out", i_out_a, 20);
    checkOutput("steady_q_out", q_out_a, -20);

    $display("[TB] reset during Q accumulation");
    i_a = 10; q_a = 5;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_i_out", i_out_a, 0);
    checkOutput("abort_q_out", q_out_a, 0);
    checkOutput("abort_valid", valid_a, 0);
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_overrun", ovr_a, 0);
    start_a = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) begin mi[k] = 0; mq[k] = 0; end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) start_a = 1'b1;

    $display("[TB] impulse on I");
    applyStimulus(63, 0, 16, 1'b0);
    for (int t = 0; t < 5; t++) applyStimulus(0, 0, 1, 1'b0);
    checkOutput("impulse_tail_i", i_out_a, 0);

    $display("[TB] start dropped mid computation");
    applyStimulus(24, -16, 1, 1'b1);
    activity = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy_a || valid_a) activity++;
    end
    checkOutput("idle_after_stop", activity, 0);
    checkOutput("no_overrun_main", ovr_a, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("[TB] divider of 8 forces overrun");
    @(negedge clk);
    start_b = 1'b1; i_b = 8; q_b = -8;
    repeat (8) @(posedge clk); #1;
    checkOutput("div8_overrun_first", ovr_b, 0);
    i_b = 16; q_b = -16;
    repeat (8) @(posedge clk); #1;
    checkOutput("div8_overrun_second", ovr_b, 1);
    i_b = 24; q_b = -24;
    repeat (8) @(posedge clk);
    repeat (12) @(posedge clk); #1;
    checkOutput("div8_valid_count", b_cnt, 2);
    checkOutput("div8_window_i", b_last_i, expect_out(24, 8, 0, 0, 3));
    checkOutput("div8_window_q", b_last_q, expect_out(-24, -8, 0, 0, 3));
    @(negedge clk) start_b = 1'b0;
    @(posedge clk); #1;
    checkOutput("div8_overrun_cleared", ovr_b, 0);

    $display("[TB] zero shift with full-scale input");
    @(negedge clk);
    start_c = 1'b1; i_c = 63; q_c = 0;
    repeat (76) @(posedge clk); #1;
    checkOutput("shift0_valid_count", c_cnt, 4);
    checkOutput("shift0_i_out", c_last_i, expect_out(63, 63, 63, 63, 0));
    checkOutput("shift0_q_out", c_last_q, expect_out(0, 0, 0, 0, 0));
    start_c = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
